// File: rtl/facto_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// facto_seq_ctrl_if
// Bundles the command, multiplier-handshake and status signals of
// facto_seq_ctrl.
//   slave  : the sequencer side (consumes commands and multiplier results,
//            drives the factor/accumulator, the multiplier strobes and status)
//   master : the environment side (issues commands, models the multiplier)
// Signals:
//   opstart/opclear/mode/operand/count : command inputs to the sequencer
//   m_opdone/m_result                  : external multiplier completion/product
//   multiplier/multiplicand            : operands presented to the multiplier
//   m_opstart/m_opclear                : multiplier start / clear strobes
//   result/busy/done/overflow          : sequencer status
// ---------------------------------------------------------------------------
interface facto_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    logic                 opstart;
    logic                 opclear;
    logic                 mode;
    logic [WIDTH-1:0]     operand;
    logic [WIDTH-1:0]     count;
    logic                 m_opdone;
    logic [2*WIDTH-1:0]   m_result;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic                 m_opstart;
    logic                 m_opclear;
    logic [WIDTH-1:0]     result;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport slave (
        input  opstart, opclear, mode, operand, count, m_opdone, m_result,
        output multiplier, multiplicand, m_opstart, m_opclear,
               result, busy, done, overflow
    );

    modport master (
        output opstart, opclear, mode, operand, count, m_opdone, m_result,
        input  multiplier, multiplicand, m_opstart, m_opclear,
               result, busy, done, overflow
    );
endinterface

// File: rtl/facto_seq_ctrl.sv
// ---------------------------------------------------------------------------
// facto_seq_ctrl
// Sequences an external multiplier to compute either n! (mode 0) or the
// falling product n*(n-1)*...*(n-k+1) (mode 1). Each multiply is one
// CHECK -> MUL_REQ -> MUL_WAIT round trip; the accumulator keeps the low
// WIDTH bits of each product and a sticky flag records any lost high bits.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : facto_seq_ctrl_if.slave (commands, multiplier handshake, status)
// ---------------------------------------------------------------------------
module facto_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    facto_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        MUL_REQ  = 3'd2,
        MUL_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;          // next factor to multiply in
    logic [WIDTH-1:0] rem_q, rem_d;      // multiplies still owed (mode 1)
    logic [WIDTH-1:0] acc_q, acc_d;      // running product, low WIDTH bits
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             mclr_q, mclr_d;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        mclr_d   = 1'b0;

        if (bus.opclear) begin
            // Abort has priority over any start request or multiplier strobe.
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            mclr_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.opstart) begin
                        n_d     = bus.operand;
                        mode_d  = bus.mode;
                        ovf_d   = 1'b0;
                        state_d = CHECK;
                        if (bus.mode && (bus.count > bus.operand)) begin
                            // Falling product passes through zero: the answer
                            // is 0 and no multiplies are needed (rem = 0 makes
                            // CHECK finish immediately).
                            rem_d = '0;
                            acc_d = '0;
                        end else begin
                            rem_d = bus.mode ? bus.count : bus.operand;
                            acc_d = ONE;
                        end
                    end
                end
                CHECK: begin
                    if ((!mode_q && (n_q <= ONE)) || (mode_q && (rem_q == '0))) begin
                        state_d = DONE;
                    end else begin
                        state_d  = MUL_REQ;
                        mplier_d = n_q;
                        mcand_d  = acc_q;
                    end
                end
                MUL_REQ: begin
                    state_d = MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (bus.m_opdone) begin
                        acc_d   = bus.m_result[WIDTH-1:0];
                        ovf_d   = ovf_q | (|bus.m_result[2*WIDTH-1:WIDTH]);
                        n_d     = n_q - ONE;
                        rem_d   = rem_q - ONE;
                        state_d = CHECK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mclr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
            mclr_q   <= mclr_d;
        end
    end

    assign bus.result       = acc_q;
    assign bus.multiplier   = mplier_q;
    assign bus.multiplicand = mcand_q;
    assign bus.overflow     = ovf_q;
    assign bus.m_opclear    = mclr_q;
    assign bus.m_opstart    = (state_q == MUL_REQ);
    assign bus.done         = (state_q == DONE);
    assign bus.busy         = (state_q == CHECK) || (state_q == MUL_REQ) ||
                              (state_q == MUL_WAIT);

endmodule

// File: tb/tb_facto_seq_ctrl.sv
module tb_facto_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    facto_seq_ctrl_if #(.WIDTH(64)) b64();
    facto_seq_ctrl_if #(.WIDTH(8))  b8();

    facto_seq_ctrl #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(b64));
    facto_seq_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    int total = 0;
    int bad   = 0;

    // ---------------- multiplier models ----------------
    int            lat64 = 3;
    int            pend64 = 0;
    int            mul_total64 = 0;
    logic [63:0]   fac64 [256];
    logic [127:0]  prod64;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend64         <= 0;
            b64.m_opdone   <= 1'b0;
            b64.m_result   <= '0;
        end else begin
            b64.m_opdone <= 1'b0;
            if (b64.m_opstart) begin
                mul_total64                <= mul_total64 + 1;
                fac64[mul_total64 % 256]   <= b64.multiplier;
            end
            if (pend64 > 1) begin
                pend64 <= pend64 - 1;
            end else if (pend64 == 1) begin
                pend64       <= 0;
                b64.m_opdone <= 1'b1;
                b64.m_result <= prod64;
            end else if (b64.m_opstart) begin
                pend64 <= lat64;
                prod64 <= {64'd0, b64.multiplier} * {64'd0, b64.multiplicand};
            end
        end
    end

    int            pend8 = 0;
    int            mul_total8 = 0;
    logic [15:0]   prod8;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend8        <= 0;
            b8.m_opdone  <= 1'b0;
            b8.m_result  <= '0;
        end else begin
            b8.m_opdone <= 1'b0;
            if (b8.m_opstart) mul_total8 <= mul_total8 + 1;
            if (pend8 > 1) begin
                pend8 <= pend8 - 1;
            end else if (pend8 == 1) begin
                pend8       <= 0;
                b8.m_opdone <= 1'b1;
                b8.m_result <= prod8;
            end else if (b8.m_opstart) begin
                pend8 <= 2;
                prod8 <= {8'd0, b8.multiplier} * {8'd0, b8.multiplicand};
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_model(input bit mode, input logic [63:0] n,
                                      input logic [63:0] k, input int w,
                                      output logic [63:0] res, output bit ovf,
                                      output int muls);
        logic [127:0] acc, p, mask;
        logic [63:0]  fac;
        mask = (128'd1 << w) - 128'd1;
        acc  = 128'd1;
        ovf  = 1'b0;
        muls = 0;
        if (!mode) begin
            for (longint f = longint'(n); f >= 2; f--) begin
                fac = 64'(f);
                p = acc * {64'd0, fac};
                if ((p >> w) != 0) ovf = 1'b1;
                acc = p & mask;
                muls++;
            end
        end else if (k > n) begin
            acc = 128'd0;
        end else begin
            for (longint i = 0; i < longint'(k); i++) begin
                fac = n - 64'(i);
                p = acc * {64'd0, fac};
                if ((p >> w) != 0) ovf = 1'b1;
                acc = p & mask;
                muls++;
            end
        end
        res = acc[63:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on the 64-bit instance.
    task automatic run64(input bit mode, input logic [63:0] n, input logic [63:0] k,
                         input int lat, input bit disturb,
                         input logic [63:0] er, input bit eo, input int em);
        int base;
        bit fin;
        lat64 = lat;
        base  = mul_total64;
        b64.mode = mode; b64.operand = n; b64.count = k; b64.opstart = 1'b1;
        tick();
        b64.opstart = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            tick();
            b64.opstart = 1'b0;
            if (b64.done) fin = 1'b1;
            else if (disturb && em > 0 && c == 0) begin
                // start request while busy must be ignored
                b64.opstart = 1'b1;
                b64.operand = n + 64'd3;
                b64.mode    = ~mode;
            end
        end
        check("done_reached", fin, 1'b1);
        check("result", b64.result, er);
        check("overflow", b64.overflow, eo);
        check("mul_count", mul_total64 - base, em);
        check("busy_at_done", b64.busy, 1'b0);
        for (int i = 0; i < em && i < 256; i++)
            check("factor", fac64[(base + i) % 256], n - 64'(i));
        $display("op64 mode=%0d n=%0h k=%0h lat=%0d dist=%0d result=%0h ovf=%0b muls=%0d",
                 mode, n, k, lat, disturb, b64.result, b64.overflow, mul_total64 - base);
    endtask

    task automatic run8(input bit mode, input logic [7:0] n, input logic [7:0] k,
                        input logic [7:0] er, input bit eo, input int em);
        int base;
        bit fin;
        base = mul_total8;
        b8.mode = mode; b8.operand = n; b8.count = k; b8.opstart = 1'b1;
        tick();
        b8.opstart = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            tick();
            if (b8.done) fin = 1'b1;
        end
        check("done8_reached", fin, 1'b1);
        check("result8", b8.result, er);
        check("overflow8", b8.overflow, eo);
        check("mul_count8", mul_total8 - base, em);
        $display("op8 mode=%0d n=%0d k=%0d result=%0d ovf=%0b muls=%0d",
                 mode, n, k, b8.result, b8.overflow, mul_total8 - base);
    endtask

    typedef struct {
        bit          mode;
        logic [63:0] n;
        logic [63:0] k;
        logic [63:0] er;
        bit          eo;
        int          em;
    } vec_t;

    vec_t vecs [12];
    vec_t v8   [3];

    initial begin
        logic [63:0] er;
        bit          eo;
        int          em;
        int          base;
        bit          seen;
        bit          mode_r;
        logic [63:0] n_r, k_r;

        vecs[0]  = '{1'b0, 64'd5,  64'd0,  64'd120, 1'b0, 4};
        vecs[1]  = '{1'b0, 64'd0,  64'd0,  64'd1,   1'b0, 0};
        vecs[2]  = '{1'b0, 64'd1,  64'd0,  64'd1,   1'b0, 0};
        vecs[3]  = '{1'b1, 64'd10, 64'd3,  64'd720, 1'b0, 3};
        vecs[4]  = '{1'b1, 64'd10, 64'd12, 64'd0,   1'b0, 0};
        vecs[5]  = '{1'b1, 64'd10, 64'd0,  64'd1,   1'b0, 0};
        vecs[6]  = '{1'b0, 64'd2,  64'd0,  64'd2,   1'b0, 1};
        vecs[7]  = '{1'b1, 64'd5,  64'd5,  64'd120, 1'b0, 5};
        vecs[8]  = '{1'b0, 64'd20, 64'd0,  64'd2432902008176640000, 1'b0, 19};
        vecs[9]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2, 1'b1, 2};
        vecs[10] = '{1'b1, 64'd0,  64'd0,  64'd1,   1'b0, 0};
        vecs[11] = '{1'b1, 64'd3,  64'd4,  64'd0,   1'b0, 0};
        v8[0]    = '{1'b0, 64'd6,   64'd0, 64'd208, 1'b1, 5};
        v8[1]    = '{1'b0, 64'd5,   64'd0, 64'd120, 1'b0, 4};
        v8[2]    = '{1'b1, 64'd255, 64'd2, 64'd2,   1'b1, 2};

        reset = 1'b1;
        b64.opstart = 1'b0; b64.opclear = 1'b0; b64.mode = 1'b0;
        b64.operand = '0;   b64.count = '0;
        b8.opstart  = 1'b0; b8.opclear  = 1'b0; b8.mode  = 1'b0;
        b8.operand  = '0;   b8.count  = '0;
        #2;
        check("rst_result", b64.result, 64'd0);
        check("rst_busy", b64.busy, 1'b0);
        check("rst_done", b64.done, 1'b0);
        check("rst_overflow", b64.overflow, 1'b0);
        check("rst_m_opstart", b64.m_opstart, 1'b0);
        check("rst_m_opclear", b64.m_opclear, 1'b0);
        check("rst_multiplier", b64.multiplier, 64'd0);
        check("rst_result8", b8.result, 8'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // table-driven vectors, 64-bit instance
        for (int i = 0; i < 12; i++)
            run64(vecs[i].mode, vecs[i].n, vecs[i].k, 3, 1'b0, vecs[i].er, vecs[i].eo, vecs[i].em);

        // table-driven vectors, 8-bit instance
        for (int i = 0; i < 3; i++)
            run8(v8[i].mode, v8[i].n[7:0], v8[i].k[7:0], v8[i].er[7:0], v8[i].eo, v8[i].em);

        // operand 0 / 1: finished by the second edge after opstart
        for (int i = 0; i < 2; i++) begin
            base = mul_total64;
            b64.mode = 1'b0; b64.operand = 64'(i); b64.opstart = 1'b1;
            tick();
            b64.opstart = 1'b0;
            check("triv_busy_edge1", b64.busy, 1'b1);
            tick();
            check("triv_done_edge2", b64.done, 1'b1);
            check("triv_result", b64.result, 64'd1);
            check("triv_no_mul", mul_total64 - base, 0);
            $display("trivial n=%0d result=%0h done=%0b", i, b64.result, b64.done);
        end

        // opclear during MUL_WAIT, multiplier answers late
        lat64 = 10;
        base  = mul_total64;
        b64.mode = 1'b0; b64.operand = 64'd5; b64.opstart = 1'b1;
        tick();
        b64.opstart = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (b64.m_opstart) seen = 1'b1;
            else tick();
        end
        check("clr_saw_mstart", seen, 1'b1);
        tick(); tick();
        b64.opclear = 1'b1;
        tick();
        b64.opclear = 1'b0;
        check("clr_m_opclear", b64.m_opclear, 1'b1);
        check("clr_busy", b64.busy, 1'b0);
        check("clr_done", b64.done, 1'b0);
        check("clr_result", b64.result, 64'd0);
        tick();
        check("clr_pulse_width", b64.m_opclear, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (b64.m_opdone) seen = 1'b1;
        end
        check("clr_late_strobe", seen, 1'b1);
        check("clr_after_result", b64.result, 64'd0);
        check("clr_after_busy", b64.busy, 1'b0);
        check("clr_after_done", b64.done, 1'b0);
        check("clr_mul_count", mul_total64 - base, 1);
        $display("clear sequence result=%0h busy=%0b done=%0b", b64.result, b64.busy, b64.done);

        // asynchronous reset in MUL_WAIT
        lat64 = 5;
        b64.mode = 1'b0; b64.operand = 64'd5; b64.opstart = 1'b1;
        tick();
        b64.opstart = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (b64.m_opstart) seen = 1'b1;
            else tick();
        end
        check("rst_mid_saw_mstart", seen, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", b64.busy, 1'b0);
        check("arst_done", b64.done, 1'b0);
        check("arst_result", b64.result, 64'd0);
        check("arst_multiplier", b64.multiplier, 64'd0);
        check("arst_multiplicand", b64.multiplicand, 64'd0);
        check("arst_m_opstart", b64.m_opstart, 1'b0);
        check("arst_overflow", b64.overflow, 1'b0);
        tick(); tick();
        reset = 1'b0;
        base = mul_total64;
        repeat (5) tick();
        check("arst_no_mstart", mul_total64 - base, 0);
        $display("async reset sequence busy=%0b result=%0h", b64.busy, b64.result);
        run64(1'b0, 64'd4, 64'd0, 3, 1'b0, 64'd24, 1'b0, 3);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            mode_r = 1'($urandom_range(0, 1));
            n_r    = 64'($urandom_range(0, 24));
            k_r    = 64'($urandom_range(0, 26));
            ref_model(mode_r, n_r, k_r, 64, er, eo, em);
            run64(mode_r, n_r, k_r, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), er, eo, em);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
